stage5_writeback: RTL and testbench

//  Final pipeline stage, fed by the MEM stage. Registers the MEM/WB pipeline state
//  (ALU result, load data, destination register, WB control, IO flag) and drives the

---
 rtl/stage5_writeback.sv | 139 +++++++++++++
 tb/tb_stage5_writeback.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage5_writeback.sv
// stage5_writeback: MEM/WB pipeline register, register-file write port, and IO FIFO drained to the board IO device.
// Optional macro WB_BYPASS_EN drives FwdEn/FwdReg/FwdData from the write port; otherwise those outputs are tied to 0.
module stage5_writeback #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int IO_DEPTH = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [DATA_W-1:0] ResultRType,
    input  logic [DATA_W-1:0] MemOp,
    input  logic [REG_W-1:0]  WriteReg,
    input  logic [1:0]        WBReg,
    input  logic              IOInst,
    output logic              IOStall,
    output logic              RegWrite,
    output logic [REG_W-1:0]  WrAddr,
    output logic [DATA_W-1:0] WrData,
    output logic              io_valid,
    output logic [DATA_W-1:0] io_data,
    input  logic              io_ack,
    output logic              FwdEn,
    output logic [REG_W-1:0]  FwdReg,
    output logic [DATA_W-1:0] FwdData,
    output logic [1:0]        IoStateDbg
);

    localparam int PTR_W = $clog2(IO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IO_DEPTH);

    typedef enum logic [1:0] {
        IO_IDLE = 2'd0,
        IO_SEND = 2'd1,
        IO_GAP  = 2'd2
    } ioState_t;

    ioState_t ioState, ioNext;

    logic [DATA_W-1:0] aluQ, memQ;
    logic [REG_W-1:0]  regQ;
    logic              regWriteQ, memToRegQ, validQ;

    logic [DATA_W-1:0] fifoMem [IO_DEPTH];
    logic [PTR_W-1:0]  wrPtr, rdPtr;
    logic [CNT_W-1:0]  fifoCnt;
    logic              fifoFull, fifoEmpty, push, pop;

    // Full is taken from the registered count, so a pop in this cycle cannot release IOStall early.
    assign fifoFull  = (fifoCnt == FULL_CNT);
    assign fifoEmpty = (fifoCnt == '0);
    assign IOStall   = IOInst & fifoFull;
    assign push      = IOInst & ~Flush & ~IOStall & ~Stall;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            aluQ      <= '0;
            memQ      <= '0;
            regQ      <= '0;
            regWriteQ <= 1'b0;
            memToRegQ <= 1'b0;
            validQ    <= 1'b0;
        end else if (Flush || IOStall) begin
            validQ <= 1'b0;
        end else if (!Stall) begin
            aluQ      <= ResultRType;
            memQ      <= MemOp;
            regQ      <= WriteReg;
            regWriteQ <= WBReg[1];
            memToRegQ <= WBReg[0];
            validQ    <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifoMem[wrPtr] <= ResultRType;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            fifoCnt <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            if (push && !pop)      fifoCnt <= fifoCnt + CNT_W'(1);
            else if (pop && !push) fifoCnt <= fifoCnt - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) ioState <= IO_IDLE;
        else        ioState <= ioNext;
    end

    // IO handshake: io_valid/io_data stay stable while in SEND; a transfer happens on any edge
    // where io_valid && io_ack, after which io_valid drops for exactly one GAP cycle.
    always_comb begin
        ioNext   = ioState;
        io_valid = 1'b0;
        pop      = 1'b0;
        case (ioState)
            IO_IDLE: if (!fifoEmpty) ioNext = IO_SEND;
            IO_SEND: begin
                io_valid = 1'b1;
                if (io_ack) begin
                    pop    = 1'b1;
                    ioNext = IO_GAP;
                end
            end
            IO_GAP:  ioNext = fifoEmpty ? IO_IDLE : IO_SEND;
            default: ioNext = IO_IDLE;
        endcase
    end

    assign io_data    = io_valid ? fifoMem[rdPtr] : '0;
    assign IoStateDbg = ioState;

    // $0 is hardwired, so a write addressed to it is dropped here rather than in the register file.
    assign RegWrite = validQ & regWriteQ & (regQ != '0);
    assign WrAddr   = regQ;
    assign WrData   = memToRegQ ? memQ : aluQ;

`ifdef WB_BYPASS_EN
    assign FwdEn   = RegWrite;
    assign FwdReg  = WrAddr;
    assign FwdData = WrData;
`else
    assign FwdEn   = 1'b0;
    assign FwdReg  = '0;
    assign FwdData = '0;
`endif

endmodule

// File: tb/tb_stage5_writeback.sv
// Directed bench for stage5_writeback: table of writeback vectors plus hand sequences for IO FIFO, stall and reset.
module tb_stage5_writeback;

    logic        Clk, Rst_n, Stall, Flush, IOInst, io_ack;
    logic [31:0] ResultRType, MemOp;
    logic [4:0]  WriteReg;
    logic [1:0]  WBReg;
    logic        IOStall, RegWrite, io_valid, FwdEn;
    logic [4:0]  WrAddr, FwdReg;
    logic [31:0] WrData, io_data, FwdData;
    logic [1:0]  IoStateDbg;

    int nCmp = 0;
    int nErr = 0;
    logic [31:0] expQ[$];

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] res;
        logic [31:0] mem;
        logic [4:0]  wr;
        logic [1:0]  wb;
        logic        expRw;
        logic [4:0]  expAddr;
        logic [31:0] expData;
        logic        chkData;
    } vec_t;

    vec_t vecs[13];

    stage5_writeback dut (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush),
        .ResultRType(ResultRType), .MemOp(MemOp), .WriteReg(WriteReg), .WBReg(WBReg),
        .IOInst(IOInst), .IOStall(IOStall), .RegWrite(RegWrite), .WrAddr(WrAddr),
        .WrData(WrData), .io_valid(io_valid), .io_data(io_data), .io_ack(io_ack),
        .FwdEn(FwdEn), .FwdReg(FwdReg), .FwdData(FwdData), .IoStateDbg(IoStateDbg)
    );

    // Clock / watchdog
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    function automatic vec_t mkVec(input logic stall, input logic flush, input logic [31:0] res,
                                   input logic [31:0] mem, input logic [4:0] wr, input logic [1:0] wb,
                                   input logic expRw, input logic [4:0] expAddr,
                                   input logic [31:0] expData, input logic chkData);
        vec_t v;
        v.stall = stall; v.flush = flush; v.res = res; v.mem = mem; v.wr = wr; v.wb = wb;
        v.expRw = expRw; v.expAddr = expAddr; v.expData = expData; v.chkData = chkData;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkWb(input string name, input logic expRw, input logic [4:0] expAddr,
                           input logic [31:0] expData, input logic chkData);
        check({name, "_rw"}, {31'd0, RegWrite}, {31'd0, expRw});
        if (chkData) begin
            check({name, "_addr"}, {27'd0, WrAddr}, {27'd0, expAddr});
            check({name, "_data"}, WrData, expData);
        end
`ifdef WB_BYPASS_EN
        check({name, "_fwden"}, {31'd0, FwdEn}, {31'd0, expRw});
        if (chkData) begin
            check({name, "_fwdreg"}, {27'd0, FwdReg}, {27'd0, expAddr});
            check({name, "_fwddata"}, FwdData, expData);
        end
`else
        check({name, "_fwden"}, {31'd0, FwdEn}, 32'd0);
        check({name, "_fwdreg"}, {27'd0, FwdReg}, 32'd0);
        check({name, "_fwddata"}, FwdData, 32'd0);
`endif
    endtask

    task automatic checkIo(input string name, input logic expValid, input logic [31:0] expData,
                           input logic [1:0] expState);
        check({name, "_valid"}, {31'd0, io_valid}, {31'd0, expValid});
        check({name, "_data"}, io_data, expData);
        check({name, "_state"}, {30'd0, IoStateDbg}, {30'd0, expState});
    endtask

    // Driver tasks
    task automatic driveIdle();
        Stall = 1'b0; Flush = 1'b0; IOInst = 1'b0; io_ack = 1'b0;
        ResultRType = '0; MemOp = '0; WriteReg = '0; WBReg = 2'b00;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic driveIo(input logic [31:0] res, input logic [4:0] wr);
        IOInst = 1'b1; ResultRType = res; WriteReg = wr; WBReg = 2'b10; MemOp = '0;
    endtask

    initial begin
        vecs[0]  = mkVec(0, 0, 32'h1234,     32'h0,        5'd5,  2'b10, 1, 5'd5,  32'h1234,     1);
        vecs[1]  = mkVec(0, 0, 32'h40,       32'hDEADBEEF, 5'd7,  2'b11, 1, 5'd7,  32'hDEADBEEF, 1);
        vecs[2]  = mkVec(0, 0, 32'h40,       32'hDEADBEEF, 5'd0,  2'b11, 0, 5'd0,  32'hDEADBEEF, 1);
        vecs[3]  = mkVec(0, 0, 32'h55,       32'h0,        5'd9,  2'b00, 0, 5'd9,  32'h55,       1);
        vecs[4]  = mkVec(0, 0, 32'h11,       32'h77,       5'd10, 2'b01, 0, 5'd10, 32'h77,       1);
        vecs[5]  = mkVec(0, 0, 32'h1234,     32'h0,        5'd5,  2'b10, 1, 5'd5,  32'h1234,     1);
        vecs[6]  = mkVec(0, 1, 32'h99,       32'h0,        5'd3,  2'b10, 0, 5'd0,  32'h0,        0);
        vecs[7]  = mkVec(0, 0, 32'hFFFFFFFF, 32'h0,        5'd31, 2'b10, 1, 5'd31, 32'hFFFFFFFF, 1);
        vecs[8]  = mkVec(1, 0, 32'h22,       32'h0,        5'd4,  2'b10, 1, 5'd31, 32'hFFFFFFFF, 1);
        vecs[9]  = mkVec(1, 0, 32'h22,       32'h0,        5'd4,  2'b10, 1, 5'd31, 32'hFFFFFFFF, 1);
        vecs[10] = mkVec(1, 0, 32'h22,       32'h0,        5'd4,  2'b10, 1, 5'd31, 32'hFFFFFFFF, 1);
        vecs[11] = mkVec(0, 0, 32'h22,       32'h0,        5'd4,  2'b10, 1, 5'd4,  32'h22,       1);
        vecs[12] = mkVec(1, 1, 32'h33,       32'h0,        5'd6,  2'b10, 0, 5'd0,  32'h0,        0);

        // Reset state
        driveIdle();
        Rst_n = 1'b0;
        tick();
        tick();
        checkWb("reset", 1'b0, 5'd0, 32'h0, 1'b1);
        checkIo("reset_io", 1'b0, 32'h0, S_IDLE);
        check("reset_iostall", {31'd0, IOStall}, 32'd0);
        Rst_n = 1'b1;

        // Writeback vector table
        for (int i = 0; i < 13; i++) begin
            Stall = vecs[i].stall; Flush = vecs[i].flush; ResultRType = vecs[i].res;
            MemOp = vecs[i].mem; WriteReg = vecs[i].wr; WBReg = vecs[i].wb;
            tick();
            checkWb($sformatf("vec%0d", i), vecs[i].expRw, vecs[i].expAddr, vecs[i].expData, vecs[i].chkData);
            check($sformatf("vec%0d_iovalid", i), {31'd0, io_valid}, 32'd0);
        end
        driveIdle();
        tick();

        // Single IO write held 4 cycles, one GAP, back to IDLE; io_ack in IDLE ignored
        driveIo(32'hA5, 5'd8);
        expQ.push_back(32'hA5);
        tick();
        checkWb("io1_push", 1'b1, 5'd8, 32'hA5, 1'b1);
        checkIo("io1_idle", 1'b0, 32'h0, S_IDLE);
        driveIdle();
        io_ack = 1'b1;
        tick();
        io_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkIo($sformatf("io1_send%0d", i), 1'b1, expQ[0], S_SEND);
            if (i == 3) io_ack = 1'b1;
            tick();
        end
        void'(expQ.pop_front());
        io_ack = 1'b0;
        checkIo("io1_gap", 1'b0, 32'h0, S_GAP);
        tick();
        checkIo("io1_idle_after", 1'b0, 32'h0, S_IDLE);

        // Three back-to-back IO writes with FIFO of 2: third stalls until one pop
        driveIo(32'd1, 5'd1);
        expQ.push_back(32'd1);
        check("io3_stall_a", {31'd0, IOStall}, 32'd0);
        tick();
        checkWb("io3_cap1", 1'b1, 5'd1, 32'd1, 1'b1);
        driveIo(32'd2, 5'd2);
        expQ.push_back(32'd2);
        check("io3_stall_b", {31'd0, IOStall}, 32'd0);
        tick();
        checkWb("io3_cap2", 1'b1, 5'd2, 32'd2, 1'b1);
        checkIo("io3_send1", 1'b1, expQ[0], S_SEND);
        driveIo(32'd3, 5'd3);
        check("io3_stall_c", {31'd0, IOStall}, 32'd1);
        tick();
        check("io3_bubble_rw", {31'd0, RegWrite}, 32'd0);
        checkIo("io3_send1_hold", 1'b1, expQ[0], S_SEND);
        io_ack = 1'b1;
        check("io3_stall_same_pop", {31'd0, IOStall}, 32'd1);
        tick();
        void'(expQ.pop_front());
        io_ack = 1'b0;
        expQ.push_back(32'd3);
        check("io3_stall_lifted", {31'd0, IOStall}, 32'd0);
        check("io3_still_bubble", {31'd0, RegWrite}, 32'd0);
        checkIo("io3_gap1", 1'b0, 32'h0, S_GAP);
        tick();
        checkWb("io3_retry", 1'b1, 5'd3, 32'd3, 1'b1);
        checkIo("io3_send2", 1'b1, expQ[0], S_SEND);
        driveIdle();
        io_ack = 1'b1;
        tick();
        void'(expQ.pop_front());
        io_ack = 1'b0;
        checkIo("io3_gap2", 1'b0, 32'h0, S_GAP);
        tick();
        checkIo("io3_send3", 1'b1, expQ[0], S_SEND);
        io_ack = 1'b1;
        tick();
        void'(expQ.pop_front());
        io_ack = 1'b0;
        checkIo("io3_gap3", 1'b0, 32'h0, S_GAP);
        tick();
        checkIo("io3_idle", 1'b0, 32'h0, S_IDLE);
        check("io3_queue_drained", expQ.size(), 32'd0);

        // Flush suppresses the IO push
        Flush = 1'b1;
        driveIo(32'h66, 5'd6);
        tick();
        check("flushio_rw", {31'd0, RegWrite}, 32'd0);
        driveIdle();
        tick();
        checkIo("flushio_none", 1'b0, 32'h0, S_IDLE);
        tick();
        checkIo("flushio_none2", 1'b0, 32'h0, S_IDLE);

        // Reset while io_valid is high discards pending data
        driveIo(32'h5A, 5'd2);
        tick();
        driveIdle();
        tick();
        checkIo("rst_pre", 1'b1, 32'h5A, S_SEND);
        Rst_n = 1'b0;
        tick();
        checkIo("rst_io", 1'b0, 32'h0, S_IDLE);
        checkWb("rst_wb", 1'b0, 5'd0, 32'h0, 1'b1);
        Rst_n = 1'b1;
        tick();
        tick();
        checkIo("rst_empty", 1'b0, 32'h0, S_IDLE);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
